// File: rtl/mdc_frame_tx_if.sv
// Load, frame and result bundle between the host-side frame transmitter and its peers.
// master: the transmitter itself. slave: the host/core side that drives loads and results.
interface mdc_frame_tx_if;
    logic         ld_valid;
    logic         ld_ready;
    logic [10:0]  ld_data;
    logic [4:0]   ld_mode;
    logic         in_valid;
    logic [14:0]  in_data;
    logic [8:0]   in_mode;
    logic         out_valid;
    logic [206:0] out_data;
    logic         resp_valid;
    logic [206:0] resp_data;
    logic         err_timeout;
    logic         err_overlap;

    modport master (
        input  ld_valid, ld_data, ld_mode, out_valid, out_data,
        output ld_ready, in_valid, in_data, in_mode, resp_valid, resp_data,
               err_timeout, err_overlap
    );

    modport slave (
        output ld_valid, ld_data, ld_mode, out_valid, out_data,
        input  ld_ready, in_valid, in_data, in_mode, resp_valid, resp_data,
               err_timeout, err_overlap
    );
endinterface

// File: rtl/mdc_frame_tx.sv
// Frame transmitter for the Hamming-protected matrix-determinant link.
// Buffers 16 words + mode, sends a 16-beat Hamming-encoded frame, then waits
// for the core result or a timeout.
// Optional feature macro: FRAME_TX_ERRINJ_EN (single-bit codeword error injection).
module mdc_frame_tx #(
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
`ifdef FRAME_TX_ERRINJ_EN
    input  logic       inj_en,
    input  logic [3:0] inj_word,
    input  logic [3:0] inj_pos,
`endif
    mdc_frame_tx_if.master bus
);
    localparam int unsigned NWORD   = 16;
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_SEND, S_WAIT} state_t;

    // Hamming(15,11): position p lands on bit 15-p, parity at 1,2,4,8.
    function automatic logic [14:0] enc15(input logic [10:0] d);
        logic [15:1] cw;
        cw     = '0;
        cw[3]  = d[10]; cw[5]  = d[9]; cw[6]  = d[8]; cw[7]  = d[7];
        cw[9]  = d[6];  cw[10] = d[5]; cw[11] = d[4]; cw[12] = d[3];
        cw[13] = d[2];  cw[14] = d[1]; cw[15] = d[0];
        cw[1]  = ^{cw[3], cw[5], cw[7], cw[9], cw[11], cw[13], cw[15]};
        cw[2]  = ^{cw[3], cw[6], cw[7], cw[10], cw[11], cw[14], cw[15]};
        cw[4]  = ^{cw[5], cw[6], cw[7], cw[12], cw[13], cw[14], cw[15]};
        cw[8]  = ^cw[15:9];
        return {cw[1], cw[2], cw[3], cw[4], cw[5], cw[6], cw[7], cw[8],
                cw[9], cw[10], cw[11], cw[12], cw[13], cw[14], cw[15]};
    endfunction

    // Shortened Hamming(9,5) for the mode: position p lands on bit 9-p.
    function automatic logic [8:0] enc9(input logic [4:0] m);
        logic [9:1] cw;
        cw    = '0;
        cw[3] = m[4]; cw[5] = m[3]; cw[6] = m[2]; cw[7] = m[1]; cw[9] = m[0];
        cw[1] = ^{cw[3], cw[5], cw[7], cw[9]};
        cw[2] = ^{cw[3], cw[6], cw[7]};
        cw[4] = ^{cw[5], cw[6], cw[7]};
        cw[8] = cw[9];
        return {cw[1], cw[2], cw[3], cw[4], cw[5], cw[6], cw[7], cw[8], cw[9]};
    endfunction

    state_t         r_state;
    logic [3:0]     r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic           r_ld_ready;
    logic           r_in_valid;
    logic [14:0]    r_in_data;
    logic [8:0]     r_in_mode;
    logic           r_resp_valid;
    logic [206:0]   r_resp_data;
    logic           r_err_timeout;
    logic           r_err_overlap;
    logic [10:0]    r_word [NWORD];
    logic [4:0]     r_mode;

    logic             w_ld_hs;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [14:0]      w_beat_data;

    assign w_ld_hs   = bus.ld_valid & r_ld_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef FRAME_TX_ERRINJ_EN
    logic       r_inj_en;
    logic [3:0] r_inj_word;
    logic [3:0] r_inj_pos;
    logic       w_sel_en;
    logic [3:0] w_sel_word;
    logic [3:0] w_sel_pos;
    logic [14:0] w_flip;

    // Beat 0 leaves on the GAP exit edge, so it uses the live settings; later beats the sampled copy.
    assign w_sel_en    = (r_state == S_GAP) ? inj_en   : r_inj_en;
    assign w_sel_word  = (r_state == S_GAP) ? inj_word : r_inj_word;
    assign w_sel_pos   = (r_state == S_GAP) ? inj_pos  : r_inj_pos;
    assign w_flip      = (w_sel_en && (w_sel_word == r_idx) && (w_sel_pos != 4'd0))
                         ? 15'(15'd1 << (4'd15 - w_sel_pos)) : 15'd0;
    assign w_beat_data = enc15(r_word[r_idx]) ^ w_flip;
`else
    assign w_beat_data = enc15(r_word[r_idx]);
`endif

    // Word/mode buffer; contents are don't-care until loaded, so no reset.
    always_ff @(posedge clk) begin
        if (w_ld_hs) begin
            r_word[r_idx] <= bus.ld_data;
            if (r_state == S_IDLE) r_mode <= bus.ld_mode;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_ld_ready    <= 1'b0;
            r_in_valid    <= 1'b0;
            r_in_data     <= '0;
            r_in_mode     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_err_timeout <= 1'b0;
            r_err_overlap <= 1'b0;
`ifdef FRAME_TX_ERRINJ_EN
            r_inj_en      <= 1'b0;
            r_inj_word    <= '0;
            r_inj_pos     <= '0;
`endif
        end else begin
            r_resp_valid  <= 1'b0;
            r_err_timeout <= 1'b0;
            if (r_in_valid && bus.out_valid) r_err_overlap <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_ld_ready <= 1'b1;
                    if (w_ld_hs) begin
                        r_idx   <= 4'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_ld_hs) begin
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_state    <= S_GAP;
                            r_ld_ready <= 1'b0;
                            r_cnt      <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYC)) begin
                        r_state    <= S_SEND;
                        r_in_valid <= 1'b1;
                        r_in_data  <= w_beat_data;
                        r_in_mode  <= enc9(r_mode);
                        r_idx      <= 4'd1;
`ifdef FRAME_TX_ERRINJ_EN
                        r_inj_en   <= inj_en;
                        r_inj_word <= inj_word;
                        r_inj_pos  <= inj_pos;
`endif
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SEND: begin
                    // r_idx wraps to 0 once beat 15 has been issued.
                    if (r_idx == 4'd0) begin
                        r_state    <= S_WAIT;
                        r_in_valid <= 1'b0;
                        r_in_data  <= '0;
                        r_in_mode  <= '0;
                        r_cnt      <= CNT_W'(1);
                    end else begin
                        r_in_data <= w_beat_data;
                        r_in_mode <= '0;
                        r_idx     <= r_idx + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.out_valid) begin
                        r_resp_data  <= bus.out_data;
                        r_resp_valid <= 1'b1;
                        r_ld_ready   <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                        r_err_timeout <= 1'b1;
                        r_ld_ready    <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ld_ready    = r_ld_ready;
    assign bus.in_valid    = r_in_valid;
    assign bus.in_data     = r_in_data;
    assign bus.in_mode     = r_in_mode;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_overlap = r_err_overlap;
endmodule

// File: tb/tb_mdc_frame_tx.sv
// Directed bench for mdc_frame_tx: encoding vectors, frame timing, capture,
// timeout, overlap, reset mid-frame and (with FRAME_TX_ERRINJ_EN) injection.
module tb_mdc_frame_tx;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdc_frame_tx_if bus();
`ifdef FRAME_TX_ERRINJ_EN
    logic       inj_en   = 1'b0;
    logic [3:0] inj_word = 4'd0;
    logic [3:0] inj_pos  = 4'd0;
`endif

    mdc_frame_tx #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FRAME_TX_ERRINJ_EN
        .inj_en(inj_en),
        .inj_word(inj_word),
        .inj_pos(inj_pos),
`endif
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] tw    [16];
    logic [14:0] exp_d [16];
    logic [8:0]  exp_m0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [10:0] w_even, input logic [10:0] w_odd,
                             input logic [14:0] e_even, input logic [14:0] e_odd);
        for (int i = 0; i < 16; i++) begin
            tw[i]    = (i % 2 == 0) ? w_even : w_odd;
            exp_d[i] = (i % 2 == 0) ? e_even : e_odd;
        end
    endtask

    // Load 16 words, check latency, all beats and the frame end. Leaves time in WAIT cycle 1.
    task automatic run_frame(input logic [4:0] mode, input int ov_beat, input int rst_beat);
        int  lat;
        bit  seen;
        lat = 0;
        while (bus.ld_ready !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_wait got %b exp 1", bus.ld_ready); end
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = tw[i];
            bus.ld_mode  = (i == 0) ? mode : 5'h1F;
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_mode  = '0;
        checks++;
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_gap got %b exp 0", bus.ld_ready); end
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick();
            if (bus.in_valid === 1'b1) begin seen = 1'b1; lat = c; end
        end
        checks++;
        if (lat != GAP_CYC + 1) begin errors++; $display("FAIL first_beat_latency got %0d exp %0d", lat, GAP_CYC + 1); end
        for (int b = 0; b < 16; b++) begin
            if (b > 0) tick();
            if (b == rst_beat) begin
                #1 rst = 1'b1;
                #1;
                checks++;
                if ({bus.in_valid, bus.in_data, bus.in_mode, bus.ld_ready} !== 26'h0) begin
                    errors++;
                    $display("FAIL reset_mid_frame got v=%b d=%h m=%h r=%b exp all 0",
                             bus.in_valid, bus.in_data, bus.in_mode, bus.ld_ready);
                end
                return;
            end
            bus.out_valid = (b == ov_beat);
            checks++;
            if ({bus.in_valid, bus.in_data} !== {1'b1, exp_d[b]}) begin
                errors++;
                $display("FAIL beat%0d_data got v=%b d=%h exp v=1 d=%h", b, bus.in_valid, bus.in_data, exp_d[b]);
            end
            checks++;
            if (bus.in_mode !== ((b == 0) ? exp_m0 : 9'h0)) begin
                errors++;
                $display("FAIL beat%0d_mode got %h exp %h", b, bus.in_mode, (b == 0) ? exp_m0 : 9'h0);
            end
        end
        tick();
        bus.out_valid = 1'b0;
        checks++;
        if ({bus.in_valid, bus.in_data, bus.in_mode} !== 25'h0) begin
            errors++;
            $display("FAIL frame_end got v=%b d=%h m=%h exp 0", bus.in_valid, bus.in_data, bus.in_mode);
        end
    endtask

    // Return a result on WAIT cycle cyc and check the capture.
    task automatic respond(input int cyc, input logic [206:0] d);
        for (int i = 1; i < cyc; i++) tick();
        bus.out_valid = 1'b1;
        bus.out_data  = d;
        tick();
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        checks++;
        if ({bus.resp_valid, bus.ld_ready, bus.err_timeout} !== 3'b110) begin
            errors++;
            $display("FAIL capture_flags got rv=%b rdy=%b to=%b exp 1 1 0", bus.resp_valid, bus.ld_ready, bus.err_timeout);
        end
        checks++;
        if (bus.resp_data !== d) begin errors++; $display("FAIL capture_data got %h exp %h", bus.resp_data, d); end
        tick();
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b0, d}) begin
            errors++;
            $display("FAIL capture_hold got rv=%b d=%h exp rv=0 d=%h", bus.resp_valid, bus.resp_data, d);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({bus.ld_ready, bus.in_valid, bus.in_data, bus.in_mode, bus.resp_valid,
             bus.resp_data, bus.err_timeout, bus.err_overlap} !== 236'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b to=%b ov=%b exp all 0",
                     bus.ld_ready, bus.in_valid, bus.err_timeout, bus.err_overlap);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.ld_ready); end
    endtask

    task automatic test_zero_frame();
        set_words(11'h000, 11'h000, 15'h0000, 15'h0000);
        exp_m0 = 9'h000;
        run_frame(5'h00, -1, -1);
        respond(3, {207{1'b1}});
    endtask

    task automatic test_word_mode();
        set_words(11'h000, 11'h000, 15'h0000, 15'h0000);
        tw[0]    = 11'h400;
        exp_d[0] = 15'h7000;
        exp_m0   = 9'h1C0;
        run_frame(5'h10, -1, -1);
        respond(2, 207'h5A5A);
    endtask

    task automatic test_all_ones();
        set_words(11'h7FF, 11'h7FF, 15'h7FFF, 15'h7FFF);
        exp_m0 = 9'h000;
        run_frame(5'h00, -1, -1);
        checks++;
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_wait_state got %b exp 0", bus.ld_ready); end
        respond(5, 207'h1);
    endtask

    task automatic test_timeout();
        int k;
        set_words(11'h000, 11'h000, 15'h0000, 15'h0000);
        exp_m0 = 9'h000;
        run_frame(5'h00, -1, -1);
        k = 1;
        while (bus.err_timeout !== 1'b1 && k < int'(TIMEOUT) + 50) begin tick(); k++; end
        checks++;
        if (k != int'(TIMEOUT)) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", k, TIMEOUT); end
        checks++;
        if ({bus.ld_ready, bus.resp_valid} !== 2'b10) begin
            errors++; $display("FAIL timeout_idle got rdy=%b rv=%b exp 1 0", bus.ld_ready, bus.resp_valid);
        end
        tick();
        checks++;
        if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", bus.err_timeout); end
    endtask

    task automatic test_capture_vs_timeout();
        set_words(11'h000, 11'h000, 15'h0000, 15'h0000);
        exp_m0 = 9'h000;
        run_frame(5'h00, -1, -1);
        respond(int'(TIMEOUT) - 1, 207'h3C3);
        checks++;
        if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL tie_no_timeout got %b exp 0", bus.err_timeout); end
    endtask

    task automatic test_idle_out_valid();
        bus.out_valid = 1'b1;
        bus.out_data  = 207'hDEAD;
        tick();
        tick();
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        checks++;
        if ({bus.resp_valid, bus.resp_data, bus.err_overlap} !== {1'b0, 207'h3C3, 1'b0}) begin
            errors++;
            $display("FAIL idle_out_valid got rv=%b d=%h ov=%b exp rv=0 d=3c3 ov=0", bus.resp_valid, bus.resp_data, bus.err_overlap);
        end
    endtask

    task automatic test_overlap();
        set_words(11'h001, 11'h002, 15'h6881, 15'h2882);
        exp_m0 = 9'h103;
        run_frame(5'h01, 5, -1);
        checks++;
        if ({bus.err_overlap, bus.resp_valid} !== 2'b10) begin
            errors++; $display("FAIL overlap_set got ov=%b rv=%b exp 1 0", bus.err_overlap, bus.resp_valid);
        end
        respond(4, 207'h77);
        checks++;
        if (bus.err_overlap !== 1'b1) begin errors++; $display("FAIL overlap_sticky got %b exp 1", bus.err_overlap); end
    endtask

    task automatic test_reset_mid_frame();
        set_words(11'h7FF, 11'h7FF, 15'h7FFF, 15'h7FFF);
        exp_m0 = 9'h000;
        run_frame(5'h00, -1, 7);
        checks++;
        if (bus.err_overlap !== 1'b0) begin errors++; $display("FAIL overlap_cleared got %b exp 0", bus.err_overlap); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        set_words(11'h001, 11'h002, 15'h6881, 15'h2882);
        exp_m0 = 9'h103;
        run_frame(5'h01, -1, -1);
        respond(5, 207'h1);
    endtask

`ifdef FRAME_TX_ERRINJ_EN
    task automatic test_errinj();
        set_words(11'h000, 11'h000, 15'h0000, 15'h0000);
        exp_d[2] = 15'h1000;
        exp_m0   = 9'h000;
        inj_en   = 1'b1;
        inj_word = 4'd2;
        inj_pos  = 4'd3;
        run_frame(5'h00, -1, -1);
        inj_en   = 1'b0;
        inj_word = 4'd0;
        inj_pos  = 4'd0;
        respond(5, 207'h9);
    endtask
`endif

    initial begin
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_mode   = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        test_reset();
        test_zero_frame();
        test_word_mode();
        test_all_ones();
        test_timeout();
        test_capture_vs_timeout();
        test_idle_out_valid();
        test_overlap();
        test_reset_mid_frame();
`ifdef FRAME_TX_ERRINJ_EN
        test_errinj();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
